chunk_loader: RTL and testbench

CHUNK_LOADER -- requirements
Module: chunk_loader

---
 rtl/chunk_loader.sv | 106 ++++++++++
 tb/tb_chunk_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_loader.sv
// rtl/chunk_loader.sv - frame loader: hunts for a sync byte, packs 4096 bytes into 1024 addressed 32-bit chunk writes
// Aborts a frame when the gap between accepted bytes reaches TIMEOUT_CYCLES.
module chunk_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_addr,
  output logic [3:0]  row_data_row_addr,
  output logic [1:0]  row_data_panel_addr,
  output logic        chunk_write_enable,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [1:0] {HUNT, DATA, DONE} state_t;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        ready_en;
  logic [11:0] byte_cnt;
  logic [23:0] asm_q;
  logic [15:0] idle_cnt;
  logic        xfer;
  logic        chunk_done;
  logic        last_byte;
  logic        timeout_hit;

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready    = ready_en && (state != DONE);
  assign busy        = (state == DATA);
  assign xfer        = in_valid && in_ready;
  assign chunk_done  = (state == DATA) && xfer && (byte_cnt[1:0] == 2'b11);
  assign last_byte   = (byte_cnt == 12'hFFF);
  assign timeout_hit = (state == DATA) && !xfer && (idle_cnt == IDLE_LAST);

  always_comb begin
    state_next = state;
    case (state)
      HUNT: if (xfer && in_data == SYNC_BYTE) state_next = DATA;
      DATA: begin
        if (xfer && last_byte)  state_next = DONE;
        else if (timeout_hit)   state_next = HUNT;
      end
      DONE:    state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= HUNT;
      ready_en            <= 1'b0;
      byte_cnt            <= '0;
      asm_q               <= '0;
      idle_cnt            <= '0;
      chunk_data          <= '0;
      chunk_addr          <= '0;
      row_data_row_addr   <= '0;
      row_data_panel_addr <= '0;
      chunk_write_enable  <= 1'b0;
      frame_done          <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      state              <= state_next;
      ready_en           <= 1'b1;
      chunk_write_enable <= chunk_done;
      frame_done         <= chunk_done && last_byte;
      frame_error        <= timeout_hit;

      // byte_cnt is the byte index in the frame; its upper bits are the chunk address
      if (chunk_done) begin
        chunk_data          <= {asm_q, in_data};
        chunk_addr          <= byte_cnt[5:2];
        row_data_row_addr   <= byte_cnt[9:6];
        row_data_panel_addr <= byte_cnt[11:10];
      end

      if (state == DATA) begin
        if (xfer) begin
          asm_q    <= {asm_q[15:0], in_data};
          byte_cnt <= byte_cnt + 12'd1;
          idle_cnt <= '0;
        end else if (timeout_hit) begin
          asm_q    <= '0;
          byte_cnt <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end else begin
        asm_q    <= '0;
        byte_cnt <= '0;
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chunk_loader.sv
// tb/tb_chunk_loader.sv - self-checking bench for chunk_loader with a frame-level byte-queue model
// Runs the DUT with a 16-cycle timeout so abort behaviour is reachable quickly.
`timescale 1ns/1ps
module tb_chunk_loader;

  localparam int         T    = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        chunk_write_enable;
  logic        frame_done;
  logic        frame_error;
  logic        busy;

  chunk_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .chunk_data          (chunk_data),
    .chunk_addr          (chunk_addr),
    .row_data_row_addr   (row_addr),
    .row_data_panel_addr (panel_addr),
    .chunk_write_enable  (chunk_write_enable),
    .frame_done          (frame_done),
    .frame_error         (frame_error),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: bytes of the current frame held in a queue, chunk index derived arithmetically
  logic [7:0]  m_bytes[$];
  bit          m_rdy_en = 0, m_in_frame = 0, m_done = 0;
  int          m_idle = 0;
  logic        e_we = 0, e_done = 0, e_err = 0;
  logic [31:0] e_data = 0;
  int          e_chunk = 0, e_row = 0, e_panel = 0;

  int          strobes, dones, errs, busy_cyc, err_cyc;
  logic [31:0] first_data, last_data;
  logic [9:0]  first_addr, last_addr;
  logic        last_done;

  task automatic clear_log();
    strobes = 0; dones = 0; errs = 0; busy_cyc = 0; err_cyc = 0;
    first_data = 0; last_data = 0; first_addr = 0; last_addr = 0; last_done = 0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", chunk_write_enable, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", frame_error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", chunk_data, 0);
      chk("rst_addr", {panel_addr, row_addr, chunk_addr}, 0);
      m_bytes.delete();
      m_rdy_en = 0; m_in_frame = 0; m_done = 0; m_idle = 0;
      e_we = 0; e_done = 0; e_err = 0; e_data = 0; e_chunk = 0; e_row = 0; e_panel = 0;
    end else begin
      chk("in_ready", in_ready, 32'(m_rdy_en && !m_done));
      chk("busy", busy, 32'(m_in_frame));
      chk("we", chunk_write_enable, 32'(e_we));
      chk("frame_done", frame_done, 32'(e_done));
      chk("frame_error", frame_error, 32'(e_err));
      chk("chunk_data", chunk_data, e_data);
      chk("chunk_addr", chunk_addr, 32'(e_chunk));
      chk("row_addr", row_addr, 32'(e_row));
      chk("panel_addr", panel_addr, 32'(e_panel));

      if (chunk_write_enable) begin
        if (strobes == 0) begin
          first_data = chunk_data;
          first_addr = {panel_addr, row_addr, chunk_addr};
        end
        last_data = chunk_data;
        last_addr = {panel_addr, row_addr, chunk_addr};
        last_done = frame_done;
        strobes++;
      end
      if (frame_done) dones++;
      if (frame_error) begin errs++; err_cyc = cyc; end
      if (busy) busy_cyc++;

      begin
        bit xfer;
        int s, idx;
        xfer = in_valid && m_rdy_en && !m_done;
        e_we = 0; e_done = 0; e_err = 0;
        if (m_done) begin
          m_done = 0;
        end else if (!m_in_frame) begin
          if (xfer && in_data == SYNC) begin
            m_in_frame = 1; m_bytes.delete(); m_idle = 0;
          end
        end else if (xfer) begin
          m_bytes.push_back(in_data);
          m_idle = 0;
          s = m_bytes.size();
          if (s % 4 == 0) begin
            idx = s / 4 - 1;
            e_we = 1;
            e_data = {m_bytes[s-4], m_bytes[s-3], m_bytes[s-2], m_bytes[s-1]};
            e_chunk = idx % 16; e_row = (idx / 16) % 16; e_panel = idx / 256;
            if (s == 4096) begin
              e_done = 1; m_done = 1; m_in_frame = 0;
            end
          end
        end else begin
          m_idle++;
          if (m_idle == T) begin
            e_err = 1; m_in_frame = 0;
          end
        end
        m_rdy_en = 1;
      end
    end
  end

  int last_acc;

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    if (gap > 0) idle(gap);
    in_valid = 1; in_data = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin last_acc = cyc; return; end
    end
    chk("handshake", r, 1);
  endtask

  task automatic send_frame(input int max_gap, input int nbytes);
    send_byte(SYNC, 0);
    for (int n = 0; n < nbytes; n++) begin
      logic [31:0] nv;
      nv = n;
      send_byte(nv[7:0], max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic check_full_frame(input string tag);
    chk({tag, "_strobes"}, strobes, 1024);
    chk({tag, "_first_data"}, first_data, 32'h00010203);
    chk({tag, "_first_addr"}, first_addr, 0);
    chk({tag, "_last_data"}, last_data, 32'hFCFDFEFF);
    chk({tag, "_last_addr"}, last_addr, 10'h3FF);
    chk({tag, "_last_done"}, last_done, 1);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_errs"}, errs, 0);
  endtask

  initial begin
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_ready", in_ready, 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", in_ready, 1);

    // continuous frame; data bytes include 0xA5 as ordinary data
    clear_log();
    send_frame(0, 4096);
    idle(4);
    check_full_frame("cont");
    chk("cont_busy_cycles", busy_cyc, 4096);

    // timeout: one chunk strobed, partial chunk dropped
    clear_log();
    send_byte(SYNC, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    idle(25);
    chk("to_strobes", strobes, 1);
    chk("to_data", first_data, 32'h11223344);
    chk("to_addr", first_addr, 0);
    chk("to_errs", errs, 1);
    chk("to_latency", err_cyc - last_acc, T);
    chk("to_busy_after", busy, 0);

    // garbage before sync
    clear_log();
    send_byte(8'h00, 0); send_byte(8'h5A, 0); send_byte(8'hFF, 0);
    idle(3);
    chk("garbage_strobes", strobes, 0);
    chk("garbage_busy", busy, 0);
    chk("garbage_errs", errs, 0);
    send_frame(0, 4096);
    idle(4);
    check_full_frame("after_garbage");

    // random gaps below the timeout
    clear_log();
    send_frame(5, 4096);
    idle(4);
    check_full_frame("gaps");

    // reset mid-frame
    clear_log();
    send_frame(0, 2000);
    reset_n = 0;
    #2;
    chk("async_we", chunk_write_enable, 0);
    chk("async_data", chunk_data, 0);
    chk("async_addr", {panel_addr, row_addr, chunk_addr}, 0);
    chk("async_ready", in_ready, 0);
    chk("async_busy", busy, 0);
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    idle(20);
    chk("midrst_dones", dones, 0);
    chk("midrst_errs", errs, 0);
    clear_log();
    send_frame(0, 4096);
    idle(4);
    check_full_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
